// File: rtl/order_book_pkg.sv
// Shared order-book definitions: request type codes, message type bytes,
// payload lengths and the decoder FSM state encoding.
package order_book_pkg;

  localparam logic [2:0] REQ_ADD  = 3'b100;
  localparam logic [2:0] REQ_DEL  = 3'b010;
  localparam logic [2:0] REQ_DEC  = 3'b001;
  localparam logic [2:0] REQ_NONE = 3'b000;

  localparam logic [7:0] MSG_ADD = 8'h41;
  localparam logic [7:0] MSG_DEL = 8'h44;
  localparam logic [7:0] MSG_DEC = 8'h58;

  localparam logic [4:0] LEN_ADD = 5'd16;
  localparam logic [4:0] LEN_DEL = 5'd4;
  localparam logic [4:0] LEN_DEC = 5'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ISSUE   = 2'd2
  } dec_state_t;

  function automatic logic [2:0] type_of_byte(input logic [7:0] b);
    case (b)
      MSG_ADD: return REQ_ADD;
      MSG_DEL: return REQ_DEL;
      MSG_DEC: return REQ_DEC;
      default: return REQ_NONE;
    endcase
  endfunction

  function automatic logic [4:0] payload_len(input logic [2:0] t);
    case (t)
      REQ_ADD: return LEN_ADD;
      REQ_DEL: return LEN_DEL;
      REQ_DEC: return LEN_DEC;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/order_req_decoder_if.sv
// Byte-stream input and order-book request bundle of the order request decoder.
// master = decoder side, slave = stream source / order book side.
interface order_req_decoder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_order_id;
  logic [31:0] req_quantity;
  logic [63:0] req_price;
  logic [2:0]  req_type;
  logic        err_pulse;

  modport master (
    input  in_valid, in_data, req_ready,
    output in_ready, req_valid, req_order_id, req_quantity, req_price,
           req_type, err_pulse
  );

  modport slave (
    output in_valid, in_data, req_ready,
    input  in_ready, req_valid, req_order_id, req_quantity, req_price,
           req_type, err_pulse
  );
endinterface

// File: rtl/order_req_decoder_field_shifter.sv
// Field registers of one message: steers each payload byte into order_id,
// quantity or price by its payload position, shifting big-endian.
module order_field_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [3:0]  pos,
  input  logic [7:0]  data,
  output logic [31:0] order_id,
  output logic [31:0] quantity,
  output logic [63:0] price
);

  // Payload positions 0-3 are order_id, 4-7 quantity, 8-15 price.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      order_id <= 32'd0;
      quantity <= 32'd0;
      price    <= 64'd0;
    end else if (clear) begin
      order_id <= 32'd0;
      quantity <= 32'd0;
      price    <= 64'd0;
    end else if (shift_en) begin
      case (pos[3:2])
        2'b00:   order_id <= {order_id[23:0], data};
        2'b01:   quantity <= {quantity[23:0], data};
        default: price    <= {price[55:0], data};
      endcase
    end
  end

endmodule

// File: rtl/order_req_decoder.sv
// Decodes Add/Delete/Decrease byte messages into order-book requests.
// Optional ORDER_REQ_STATS_EN adds request and error counters.
module order_req_decoder
  import order_book_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic clk,
  input  logic reset,
  order_req_decoder_if.master bus
`ifdef ORDER_REQ_STATS_EN
  ,
  output logic [15:0] stat_add,
  output logic [15:0] stat_del,
  output logic [15:0] stat_dec,
  output logic [15:0] stat_err
`endif
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  dec_state_t      state_r, state_nx_s;
  logic [4:0]      cnt_r;
  logic [2:0]      type_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            in_ready_r, req_valid_r, err_r;

  logic            accept_s, known_s, unknown_s, last_s, timeout_s, xfer_s;
  logic [2:0]      byte_type_s;
  logic [3:0]      pos_s;

  assign accept_s    = bus.in_valid && in_ready_r;
  assign byte_type_s = type_of_byte(bus.in_data);
  assign pos_s       = 4'(payload_len(type_r) - cnt_r);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state logic and single-cycle event strobes.
  always_comb begin
    state_nx_s = state_r;
    known_s    = 1'b0;
    unknown_s  = 1'b0;
    last_s     = 1'b0;
    timeout_s  = 1'b0;
    xfer_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (byte_type_s != REQ_NONE) begin
            known_s    = 1'b1;
            state_nx_s = COLLECT;
          end else begin
            unknown_s  = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      COLLECT: begin
        if (accept_s) begin
          if (cnt_r == 5'd1) begin
            last_s     = 1'b1;
            state_nx_s = ISSUE;
          end else begin
            state_nx_s = COLLECT;
          end
        end else if (to_cnt_r == TO_MAX) begin
          timeout_s  = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = COLLECT;
        end
      end
      ISSUE: begin
        if (req_valid_r && bus.req_ready) begin
          xfer_s     = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ISSUE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Byte counter, message type, timeout counter and registered handshakes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= 5'd0;
      type_r      <= REQ_NONE;
      to_cnt_r    <= '0;
      in_ready_r  <= 1'b0;
      req_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (known_s) begin
        cnt_r  <= payload_len(byte_type_s);
        type_r <= byte_type_s;
      end else if (timeout_s || xfer_s) begin
        cnt_r  <= 5'd0;
        type_r <= REQ_NONE;
      end else if (accept_s && state_r == COLLECT) begin
        cnt_r  <= cnt_r - 5'd1;
      end
      // Counts idle cycles only while a message is partially collected.
      if (state_r == COLLECT && !accept_s && !timeout_s) to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
      else                                               to_cnt_r <= '0;
      in_ready_r  <= (state_nx_s != ISSUE);
      req_valid_r <= (state_nx_s == ISSUE);
      err_r       <= unknown_s || timeout_s;
    end
  end

  order_field_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (timeout_s || xfer_s),
    .shift_en (accept_s && state_r == COLLECT),
    .pos      (pos_s),
    .data     (bus.in_data),
    .order_id (bus.req_order_id),
    .quantity (bus.req_quantity),
    .price    (bus.req_price)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.req_valid = req_valid_r;
  assign bus.req_type  = type_r;
  assign bus.err_pulse = err_r;

`ifdef ORDER_REQ_STATS_EN
  // Wrapping counters of issued requests per type and of error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_add <= 16'd0;
      stat_del <= 16'd0;
      stat_dec <= 16'd0;
      stat_err <= 16'd0;
    end else begin
      if (xfer_s && type_r == REQ_ADD) stat_add <= stat_add + 16'd1;
      if (xfer_s && type_r == REQ_DEL) stat_del <= stat_del + 16'd1;
      if (xfer_s && type_r == REQ_DEC) stat_dec <= stat_dec + 16'd1;
      if (err_r)                       stat_err <= stat_err + 16'd1;
    end
  end
`endif

endmodule

// File: doc/order_req_decoder.md
Name: order_req_decoder

Overview:
- Requester-side front end for the order book. Consumes a byte stream of exchange-style order messages: Add, Delete and Decrease.
- Assembles the big-endian fields of each message and issues one request per message on the order book's valid/ready request interface (valid, order_id, quantity, price, req_type).
- Sits between the network/message FIFO and the order book.

Parameters:
- TIMEOUT_CYCLES, 255: maximum idle cycles between bytes of one message before the partial message is discarded.
- TO_W, 8: width of the inter-byte timeout counter; must satisfy TIMEOUT_CYCLES < 2**TO_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  decoder accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- req_valid  out  1  request to order book pending.
- req_ready  in  1  order book ready; a request transfers when req_valid && req_ready.
- req_order_id  out  32  order id.
- req_quantity  out  32  quantity; 0 for Delete.
- req_price  out  64  price; 0 for Delete and Decrease.
- req_type  out  3  one-hot: 3'b100 add, 3'b010 delete, 3'b001 decrease.
- err_pulse  out  1  one-cycle pulse on unknown type byte or timeout.

Behaviour:
- Reset (async, active-high): all outputs 0, including in_ready and req_valid. FSM goes to IDLE. Field registers and counters clear.
- Message formats (byte 0 is the type, all fields big-endian, MSB byte first):
  - 'A' (8'h41): order_id[4], quantity[4], price[8]; 17 bytes total.
  - 'D' (8'h44): order_id[4]; 5 bytes.
  - 'X' (8'h58): order_id[4], quantity[4]; 9 bytes.
- FSM states: IDLE, COLLECT, ISSUE.
- IDLE:
  - in_ready = 1.
  - Accepted byte is a known type: latch the type, load the remaining byte count (16/8/4), go to COLLECT.
  - Unknown type: byte dropped, err_pulse next cycle, stay in IDLE.
- COLLECT:
  - in_ready = 1.
  - Each accepted byte shifts into the field register for the current field and decrements the remaining count.
  - Accepting the final byte: go to ISSUE. req_valid rises on the next cycle, so latency is 1 cycle from the last-byte handshake.
  - Timeout counter resets on each accepted byte and increments otherwise. At count == TIMEOUT_CYCLES: discard the partial message, err_pulse, return to IDLE.
- ISSUE:
  - in_ready = 0.
  - req_valid = 1; all req_* outputs are held stable until the transfer.
  - On req_valid && req_ready: req_valid drops next cycle, state returns to IDLE, fields clear.
  - No timeout in ISSUE; backpressure may last indefinitely.
- Unused fields are driven 0: Delete has quantity = 0 and price = 0; Decrease has price = 0.
- No byte is lost under in_ready deassertion; the upstream must hold in_data while in_valid && !in_ready.
- A type byte with in_valid low is ignored; no state change.
- Reset mid-message or mid-ISSUE aborts the message with no request issued. req_valid drops asynchronously.
- Back-to-back messages: the first byte of the next message is accepted in the cycle after the request transfer (one IDLE cycle minimum).

Optional Feature:
- Macro ORDER_REQ_STATS_EN.
- Defined: adds three 16-bit outputs, stat_add, stat_del and stat_dec, counting issued requests (incremented on the transfer handshake). Also adds a 16-bit stat_err counting err_pulse. All counters wrap modulo 2^16 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package order_book_pkg:
  - req_type localparams REQ_ADD = 3'b100, REQ_DEL = 3'b010, REQ_DEC = 3'b001.
  - Message type bytes MSG_ADD / MSG_DEL / MSG_DEC.
  - Payload lengths 16 / 4 / 8.
  - FSM state enum.
  - Shared with the order book.
- One sub-module, order_field_shifter. It takes the byte count position and the incoming byte, and steers the byte into order_id/quantity/price with a left-shift per field. The decoder FSM stays separate.

Test Plan:
- Add message 41 | 00000007 | 00000064 | 00000000000003E8 with req_ready = 1 → one request: order_id = 7, quantity = 100, price = 1000, req_type = 100, req_valid high exactly 1 cycle, 1 cycle after the last byte.
- Delete 44 | 00000007 with req_ready held 0 for 10 cycles → req_valid and fields stable for all 10 cycles, in_ready = 0 throughout. Transfer on the cycle req_ready goes to 1; quantity = 0, price = 0, req_type = 010.
- Decrease 58 | 0000002A | 00000005 immediately followed by an Add → two ordered requests: (42, 5, 0, 001), then the Add. No byte dropped.
- Unknown byte 8'h5A followed by a valid Delete → err_pulse high for exactly 1 cycle, then the Delete is issued correctly.
- Add truncated after 6 bytes, then idle for TIMEOUT_CYCLES → err_pulse, no request issued. A following complete Delete decodes correctly.
- Reset asserted while in ISSUE → req_valid = 0 immediately. After release, in_ready = 1 once IDLE is entered; with ORDER_REQ_STATS_EN, all stat counters read 0.
